// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU (m0, fixed priority) and the
// debug/loader port (m1, guaranteed a grant by a starvation counter).
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt;
  logic              force_m1;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

  // Priority flips to m1 for one cycle once it has been denied MAX_WAIT times.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (force_m1) begin
        m1_gnt = m1_req;
        m0_gnt = m0_req && !m1_req;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req && !m0_req;
      end
    end
  end

  always_comb begin
    ram_wea   = 1'b0;
    ram_addra = addr_q;
    ram_dina  = wdata_q;
    if (m0_gnt) begin
      ram_wea   = m0_we;
      ram_addra = m0_addr;
      ram_dina  = m0_wdata;
    end else if (m1_gnt) begin
      ram_wea   = m1_we;
      ram_addra = m1_addr;
      ram_dina  = m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      force_m1 <= 1'b0;
    end else if (!m1_req || m1_gnt) begin
      wait_cnt <= '0;
      force_m1 <= 1'b0;
    end else begin
      if (wait_cnt < MAX_CNT)
        wait_cnt <= wait_cnt + 4'd1;
      force_m1 <= (wait_cnt >= MAX_CNT - 4'd1);
    end
  end

  // Idle cycles keep the last address on the RAM so nothing spurious toggles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      addr_q    <= ram_addra;
      wdata_q   <= ram_dina;
      m0_rvalid <= m0_gnt && !m0_we;
      m1_rvalid <= m1_gnt && !m1_we;
      if (m0_rvalid)
        m0_rdata_q <= ram_douta;
      if (m1_rvalid)
        m1_rdata_q <= ram_douta;
    end
  end

  assign m0_rdata = m0_rvalid ? ram_douta : m0_rdata_q;
  assign m1_rdata = m1_rvalid ? ram_douta : m1_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-port data block RAM (1-cycle registered read, 1-bit write enable) between two requesters.
- Port 0 (m0) is the CPU load/store path. Port 1 (m1) is the debug/loader path used to preload or dump data memory.
- m0 has fixed priority. A starvation counter guarantees m1 a grant.
- The block drives the RAM address/data/write-enable and returns read data with a registered valid strobe.

Parameters:
- ADDR_W, 10, word address width (1024 words).
- DATA_W, 32, data word width.
- MAX_WAIT, 4, consecutive denied m1 cycles after which m1 is forced to win one cycle (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  CPU request valid.
- m0_we  in  1  CPU write (1) / read (0).
- m0_addr  in  ADDR_W  CPU word address.
- m0_wdata  in  DATA_W  CPU write data.
- m0_gnt  out  1  CPU request accepted this cycle.
- m0_rvalid  out  1  CPU read data valid.
- m0_rdata  out  DATA_W  CPU read data.
- m1_req / m1_we / m1_addr / m1_wdata  in  1/1/ADDR_W/DATA_W  debug port request, same meaning as m0.
- m1_gnt / m1_rvalid / m1_rdata  out  1/1/DATA_W  debug port grant, read valid, read data.
- ram_wea  out  1  RAM write enable.
- ram_addra  out  ADDR_W  RAM address.
- ram_dina  out  DATA_W  RAM write data.
- ram_douta  in  DATA_W  RAM read data (valid the cycle after the address edge).

Behaviour:
- Reset (async, rst=1):
  - m0_rvalid=0, m1_rvalid=0.
  - wait_cnt=0, force flag=0, last-read-owner register cleared.
  - While rst=1: gnt outputs=0 and ram_wea=0.
- Grant is combinational in the request cycle. A transfer occurs when req&&gnt at a rising edge. A requester holds req/we/addr/wdata stable until granted.
- Arbitration:
  - force=0: m0_gnt=m0_req; m1_gnt=m1_req&&!m0_req.
  - force=1: m1_gnt=m1_req; m0_gnt=m0_req&&!m1_req.
  - Never both grants in one cycle.
- RAM drive:
  - ram_addra/ram_dina come from the granted port.
  - ram_wea = granted port's we. ram_wea is never 1 without a grant.
  - With no grant: ram_wea=0; ram_addra holds the previous registered value, so there is no spurious access.
- Starvation counter:
  - Each edge with m1_req=1 and m1_gnt=0: wait_cnt increments. When wait_cnt reaches MAX_WAIT, force is set for the next cycle.
  - Each edge with m1_gnt=1: wait_cnt=0, force=0.
  - Edge with m1_req=0: wait_cnt=0, force=0.
  - The counter saturates at MAX_WAIT.
- Read return:
  - A granted read at edge t sets that port's rvalid=1 for exactly the cycle after t.
  - rdata = ram_douta in that cycle. The port's rdata holds its last value otherwise.
  - The other port's rvalid stays 0.
  - Writes produce no rvalid.
- Back-to-back operation:
  - One access per cycle at full throughput.
  - A read then a write to the same address in consecutive cycles returns the old data (RAM read-first).
  - A write followed by a read returns the new data.
- Simultaneous m0 read / m1 write to the same address: only the winner accesses. The loser retries later and sees the winner's effect.
- Reset mid-operation: a pending rvalid is dropped (no late strobe after rst deasserts) and the counter restarts from 0.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 5, then m0 reads addr 5 -> m0_gnt=1 both cycles; m0_rvalid=1 one cycle after the read grant with m0_rdata=0xDEADBEEF; m1_rvalid=0 throughout.
- m0_req and m1_req held high for 10 cycles, MAX_WAIT=4 -> m0 granted cycles 0-3, m1 granted cycle 4, m0 granted cycles 5-8, m1 granted cycle 9; never both grants high.
- m1 alone writes addrs 0..1023 with data=addr, then reads all back -> m1_gnt=1 every cycle; m1_rdata equals the address; address 1023 followed by 0 works with no wrap error.
- Same cycle: m0 reads addr 7, m1 writes 0x12345678 to addr 7 (force=0), old value 0 -> m0 gets 0 the next cycle, m1 is granted the following cycle, and a subsequent m0 read returns 0x12345678.
- rst pulsed high during the cycle after a granted m0 read -> m0_rvalid=0 immediately; wait_cnt=0; no rvalid pulse after rst deasserts.
- m1_req drops after 3 denied cycles, then returns -> m1 waits the full MAX_WAIT (4) cycles again before being forced.
